// File: rtl/note_field_engine.sv
// Falling-note field: up to NUM_SLOTS rectangles across NUM_LANES lanes, with spawn handshake,
// per-frame motion, hit-window judging and bottom-limit misses.
module note_field_engine #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned Y_W       = 13,
  parameter int unsigned SPEED_W   = 4,
  parameter int unsigned Y_LIMIT   = 480,
  parameter int unsigned HIT_LO    = 400,
  parameter int unsigned HIT_HI    = 440,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [SPEED_W-1:0]          speed,
  input  logic                        pause,
  input  logic                        spawn_valid,
  input  logic [LANE_W-1:0]           spawn_lane,
  input  logic [Y_W-1:0]              spawn_y,
  output logic                        spawn_ready,
  input  logic [NUM_LANES-1:0]        hit_req,
  output logic [NUM_SLOTS*Y_W-1:0]    rect_y,
  output logic [NUM_SLOTS*LANE_W-1:0] rect_lane,
  output logic [NUM_SLOTS-1:0]        rect_active,
  output logic [NUM_LANES-1:0]        hit_pulse,
  output logic [NUM_LANES-1:0]        miss_pulse,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);

  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned INC_W  = $clog2(NUM_LANES + NUM_SLOTS + 1);
  localparam int unsigned SUM_W  = CNT_W + INC_W;

  logic [NUM_SLOTS-1:0] activeQ, activeD;
  logic [Y_W-1:0]       yQ    [NUM_SLOTS];
  logic [Y_W-1:0]       yD    [NUM_SLOTS];
  logic [LANE_W-1:0]    laneQ [NUM_SLOTS];
  logic [LANE_W-1:0]    laneD [NUM_SLOTS];
  logic [NUM_LANES-1:0] hitPulseQ, hitPulseD, missPulseQ, missPulseD;
  logic [CNT_W-1:0]     hitCountQ, hitCountD, missCountQ, missCountD;

  logic [NUM_SLOTS-1:0] hitClr;
  logic [INC_W-1:0]     hitInc, missInc;
  logic [Y_W:0]         ySum;
  logic                 found, freeFound;
  logic [SLOT_W-1:0]    freeIdx;
  logic [LANE_W-1:0]    spawnLane;
  logic [SUM_W-1:0]     hitSum, missSum;

  assign spawn_ready = |(~activeQ);
  assign spawnLane   = (32'(spawn_lane) >= NUM_LANES) ? LANE_W'(NUM_LANES - 1) : spawn_lane;

  always_comb begin
    activeD    = activeQ;
    yD         = yQ;
    laneD      = laneQ;
    hitPulseD  = '0;
    missPulseD = '0;
    hitClr     = '0;
    hitInc     = '0;
    missInc    = '0;
    ySum       = '0;
    found      = 1'b0;
    freeFound  = 1'b0;
    freeIdx    = '0;

    if (!pause) begin
      // Hit judging sees only pre-edge positions; each lane takes its lowest in-window slot.
      for (int l = 0; l < int'(NUM_LANES); l++) begin
        if (hit_req[l]) begin
          found = 1'b0;
          for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            if (!found && activeQ[s] && (laneQ[s] == LANE_W'(l)) &&
                (yQ[s] >= Y_W'(HIT_LO)) && (yQ[s] <= Y_W'(HIT_HI))) begin
              found     = 1'b1;
              hitClr[s] = 1'b1;
            end
          end
          if (found) begin
            hitPulseD[l] = 1'b1;
            hitInc       = hitInc + INC_W'(1);
          end else begin
            missPulseD[l] = 1'b1;
            missInc       = missInc + INC_W'(1);
          end
        end
      end

      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        if (activeQ[s]) begin
          if (hitClr[s]) begin
            activeD[s] = 1'b0;
          end else begin
            ySum = {1'b0, yQ[s]} + (Y_W + 1)'(speed);
            if (ySum >= (Y_W + 1)'(Y_LIMIT)) begin
              activeD[s]            = 1'b0;
              missPulseD[laneQ[s]]  = 1'b1;
              missInc               = missInc + INC_W'(1);
            end else begin
              yD[s] = ySum[Y_W-1:0];
            end
          end
        end
      end
    end

    // Free slot is chosen from registered flags, so a slot retired this edge waits a frame.
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (!freeFound && !activeQ[s]) begin
        freeFound = 1'b1;
        freeIdx   = SLOT_W'(s);
      end
    end
    if (spawn_valid && freeFound) begin
      activeD[freeIdx] = 1'b1;
      yD[freeIdx]      = spawn_y;
      laneD[freeIdx]   = spawnLane;
    end
  end

  always_comb begin
    hitSum     = SUM_W'(hitCountQ) + SUM_W'(hitInc);
    missSum    = SUM_W'(missCountQ) + SUM_W'(missInc);
    hitCountD  = (hitSum[SUM_W-1:CNT_W] != '0) ? '1 : hitSum[CNT_W-1:0];
    missCountD = (missSum[SUM_W-1:CNT_W] != '0) ? '1 : missSum[CNT_W-1:0];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      activeQ    <= '0;
      hitPulseQ  <= '0;
      missPulseQ <= '0;
      hitCountQ  <= '0;
      missCountQ <= '0;
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        yQ[s]    <= '0;
        laneQ[s] <= '0;
      end
    end else begin
      activeQ    <= activeD;
      hitPulseQ  <= hitPulseD;
      missPulseQ <= missPulseD;
      hitCountQ  <= hitCountD;
      missCountQ <= missCountD;
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        yQ[s]    <= yD[s];
        laneQ[s] <= laneD[s];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : gOut
    assign rect_y[g*Y_W +: Y_W]          = yQ[g];
    assign rect_lane[g*LANE_W +: LANE_W] = laneQ[g];
  end

  assign rect_active = activeQ;
  assign hit_pulse   = hitPulseQ;
  assign miss_pulse  = missPulseQ;
  assign hit_count   = hitCountQ;
  assign miss_count  = missCountQ;

endmodule

// File: tb/tb_note_field_engine.sv
// Scoreboard bench for note_field_engine: a slot-array reference model predicts each frame,
// a negedge monitor compares the DUT snapshot against the queued prediction.
module tb_note_field_engine;

  localparam int NS   = 8;
  localparam int NL   = 4;
  localparam int YW   = 13;
  localparam int SW   = 4;
  localparam int LW   = 2;
  localparam int CW   = 6;
  localparam int YLIM = 480;
  localparam int HLO  = 400;
  localparam int HHI  = 440;
  localparam int MAXC = (1 << CW) - 1;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b1;
  logic [SW-1:0] speed = '0;
  logic          pause = 1'b0;
  logic          spawn_valid = 1'b0;
  logic [LW-1:0] spawn_lane = '0;
  logic [YW-1:0] spawn_y = '0;
  logic          spawn_ready;
  logic [NL-1:0] hit_req = '0;
  logic [NS*YW-1:0] rect_y;
  logic [NS*LW-1:0] rect_lane;
  logic [NS-1:0] rect_active;
  logic [NL-1:0] hit_pulse, miss_pulse;
  logic [CW-1:0] hit_count, miss_count;

  always #5 frame_clk = ~frame_clk;

  note_field_engine #(.NUM_SLOTS(NS), .NUM_LANES(NL), .Y_W(YW), .SPEED_W(SW), .Y_LIMIT(YLIM),
                      .HIT_LO(HLO), .HIT_HI(HHI), .CNT_W(CW)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .speed(speed), .pause(pause),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_y(spawn_y),
    .spawn_ready(spawn_ready), .hit_req(hit_req), .rect_y(rect_y), .rect_lane(rect_lane),
    .rect_active(rect_active), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {
    logic [NS-1:0]    act;
    logic [NS*YW-1:0] y;
    logic [NS*LW-1:0] lane;
    logic [NL-1:0]    hp;
    logic [NL-1:0]    mp;
    logic [CW-1:0]    hc;
    logic [CW-1:0]    mc;
    logic             rdy;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  bit mAct[NS];
  int mY[NS];
  int mLane[NS];
  int mHits, mMiss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int dutY(input int s);
    return int'(rect_y[s*YW +: YW]);
  endfunction

  function automatic void modelClear();
    for (int s = 0; s < NS; s++) begin
      mAct[s] = 0; mY[s] = 0; mLane[s] = 0;
    end
    mHits = 0;
    mMiss = 0;
  endfunction

  // One frame of the rules, applied to the slot table using the inputs present at the edge.
  task automatic modelStep();
    bit hp[NL];
    bit mp[NL];
    bit clr[NS];
    int freeIdx = -1;
    exp_t e;
    for (int l = 0; l < NL; l++) begin hp[l] = 0; mp[l] = 0; end
    for (int s = 0; s < NS; s++) begin
      clr[s] = 0;
      if (!mAct[s] && freeIdx < 0) freeIdx = s;
    end
    if (!pause) begin
      for (int l = 0; l < NL; l++) begin
        if (hit_req[l]) begin
          int pick = -1;
          for (int s = 0; s < NS; s++)
            if (pick < 0 && mAct[s] && mLane[s] == l && mY[s] >= HLO && mY[s] <= HHI) pick = s;
          if (pick >= 0) begin
            clr[pick] = 1; hp[l] = 1;
            if (mHits < MAXC) mHits++;
          end else begin
            mp[l] = 1;
            if (mMiss < MAXC) mMiss++;
          end
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (mAct[s] && !clr[s]) begin
          if (mY[s] + int'(speed) >= YLIM) begin
            mAct[s] = 0; mp[mLane[s]] = 1;
            if (mMiss < MAXC) mMiss++;
          end else begin
            mY[s] = mY[s] + int'(speed);
          end
        end
        if (clr[s]) mAct[s] = 0;
      end
    end
    if (spawn_valid && freeIdx >= 0) begin
      mAct[freeIdx]  = 1;
      mY[freeIdx]    = int'(spawn_y);
      mLane[freeIdx] = (int'(spawn_lane) >= NL) ? NL - 1 : int'(spawn_lane);
    end
    e = '0;
    for (int s = 0; s < NS; s++) begin
      e.act[s] = mAct[s];
      e.y[s*YW +: YW] = YW'(mY[s]);
      e.lane[s*LW +: LW] = LW'(mLane[s]);
      if (!mAct[s]) e.rdy = 1'b1;
    end
    for (int l = 0; l < NL; l++) begin e.hp[l] = hp[l]; e.mp[l] = mp[l]; end
    e.hc = CW'(mHits);
    e.mc = CW'(mMiss);
    expQ.push_back(e);
  endtask

  always @(negedge frame_clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("rect_active", 64'(rect_active), 64'(e.act));
      for (int s = 0; s < NS; s++) begin
        if (e.act[s]) begin
          chk($sformatf("rect_y[%0d]", s), 64'(rect_y[s*YW +: YW]), 64'(e.y[s*YW +: YW]));
          chk($sformatf("rect_lane[%0d]", s), 64'(rect_lane[s*LW +: LW]),
              64'(e.lane[s*LW +: LW]));
        end
      end
      chk("hit_pulse", 64'(hit_pulse), 64'(e.hp));
      chk("miss_pulse", 64'(miss_pulse), 64'(e.mp));
      chk("hit_count", 64'(hit_count), 64'(e.hc));
      chk("miss_count", 64'(miss_count), 64'(e.mc));
      chk("spawn_ready", 64'(spawn_ready), 64'(e.rdy));
    end
  end

  task automatic step();
    @(posedge frame_clk);
    modelStep();
    #1;
  endtask

  task automatic spawn(input int lane, input int y);
    spawn_valid = 1'b1;
    spawn_lane  = LW'(lane);
    spawn_y     = YW'(y);
    step();
    spawn_valid = 1'b0;
  endtask

  // Asserts Reset between edges with whatever inputs are pending; outputs must clear at once.
  task automatic resetDut();
    @(negedge frame_clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("reset rect_active", 64'(rect_active), 64'd0);
    chk("reset rect_y", 64'(rect_y), 64'd0);
    chk("reset pulses", 64'({hit_pulse, miss_pulse}), 64'd0);
    chk("reset counts", 64'({hit_count, miss_count}), 64'd0);
    @(posedge frame_clk);
    #1;
    chk("reset held pulses", 64'({hit_pulse, miss_pulse}), 64'd0);
    chk("reset held active", 64'(rect_active), 64'd0);
    modelClear();
    speed = '0; pause = 1'b0; spawn_valid = 1'b0; spawn_lane = '0; spawn_y = '0; hit_req = '0;
    @(negedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    int guard;
    modelClear();
    resetDut();

    // Basic motion from a single spawn
    speed = 2;
    spawn(1, 0);
    chk("t1 y after spawn", 64'(dutY(0)), 64'd0);
    step();
    chk("t1 y frame1", 64'(dutY(0)), 64'd2);
    step();
    chk("t1 y frame2", 64'(dutY(0)), 64'd4);
    chk("t1 ready", 64'(spawn_ready), 64'd1);

    // Fill all slots, hold a ninth request, free slot 5 with a hit
    resetDut();
    for (int i = 0; i < NS; i++) spawn(i % NL, (i == 5) ? 420 : 100);
    chk("t2 ready full", 64'(spawn_ready), 64'd0);
    spawn_valid = 1'b1; spawn_lane = 2'd3; spawn_y = 13'd7;
    step();
    chk("t2 held", 64'(rect_active), 64'hFF);
    hit_req = 4'b0010;
    step();
    hit_req = '0;
    chk("t2 slot5 freed", 64'(rect_active), 64'hDF);
    step();
    spawn_valid = 1'b0;
    chk("t2 refill", 64'(rect_active), 64'hFF);
    chk("t2 refill y", 64'(dutY(5)), 64'd7);

    // Bottom-limit despawn
    resetDut();
    speed = 4;
    spawn(2, 470);
    step();
    chk("t3 y474", 64'(dutY(0)), 64'd474);
    step();
    chk("t3 y478", 64'(dutY(0)), 64'd478);
    step();
    chk("t3 cleared", 64'(rect_active), 64'd0);
    chk("t3 miss_pulse", 64'(miss_pulse), 64'b0100);
    chk("t3 miss_count", 64'(miss_count), 64'd1);
    step();
    chk("t3 pulse drop", 64'(miss_pulse), 64'd0);

    // Hit in lane 2, empty hit in lane 3
    resetDut();
    spawn(2, 420);
    hit_req = 4'b1100;
    step();
    hit_req = '0;
    chk("t4 active", 64'(rect_active), 64'd0);
    chk("t4 hit_pulse", 64'(hit_pulse), 64'b0100);
    chk("t4 miss_pulse", 64'(miss_pulse), 64'b1000);
    chk("t4 counts", 64'({hit_count, miss_count}), 64'({6'd1, 6'd1}));

    // Lowest-index hit selection, then pause freezes everything
    resetDut();
    spawn(3, 0); spawn(0, 410); spawn(3, 0); spawn(3, 0); spawn(0, 430);
    hit_req = 4'b0001;
    step();
    chk("t5 one hit", 64'(rect_active), 64'h1D);
    pause = 1'b1; speed = 3;
    repeat (3) step();
    hit_req = '0;
    chk("t5 paused active", 64'(rect_active), 64'h1D);
    chk("t5 paused y4", 64'(dutY(4)), 64'd430);
    chk("t5 paused hit_count", 64'(hit_count), 64'd1);
    pause = 1'b0;

    // Reset while slots are live and a hit is pending
    resetDut();
    speed = 1;
    for (int i = 0; i < 5; i++) spawn(0, 410 + i);
    hit_req = 4'b0001;
    resetDut();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      speed       = SW'($urandom_range(0, 15));
      pause       = ($urandom_range(0, 7) == 0);
      spawn_valid = $urandom_range(0, 1) == 1;
      spawn_lane  = LW'($urandom_range(0, NL - 1));
      spawn_y     = YW'(($urandom_range(0, 9) == 0) ? $urandom_range(480, 500)
                                                    : $urandom_range(350, 479));
      hit_req     = ($urandom_range(0, 2) == 0) ? NL'($urandom_range(0, 15)) : '0;
      step();
    end
    spawn_valid = 1'b0; hit_req = '0;

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge frame_clk);
      #1;
      guard++;
    end
    chk("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_field_engine.md
Name: note_field_engine

Overview:
Multi-slot successor to the single falling rectangle: manages up to NUM_SLOTS falling note rectangles across NUM_LANES lanes. Advances each active rectangle by a programmable per-frame speed and accepts spawn requests through a valid/ready handshake. Judges per-lane hit requests against a Y hit window and retires rectangles at the bottom limit as misses. Sits between the song/chart sequencer (spawn side) and the sprite/colour mapper, which consumes the Y positions and active flags.

Parameters:
NUM_SLOTS, 8, number of simultaneous rectangles (2..16)
NUM_LANES, 4, number of lanes (1..8)
Y_W, 13, Y coordinate width
SPEED_W, 4, speed field width
Y_LIMIT, 480, Y at or beyond which an active rectangle despawns as a miss
HIT_LO, 400, inclusive lower bound of hit window
HIT_HI, 440, inclusive upper bound of hit window
CNT_W, 16, hit/miss counter width

Ports:
frame_clk  in  1  frame-rate clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
speed  in  SPEED_W  pixels added to each moving rectangle per frame
pause  in  1  1 = freeze motion, hits and misses; spawns still accepted
spawn_valid  in  1  spawn request present
spawn_lane  in  clog2(NUM_LANES)  lane for new rectangle
spawn_y  in  Y_W  start Y for new rectangle
spawn_ready  out  1  a free slot exists
hit_req  in  NUM_LANES  per-lane hit attempt this frame
rect_y  out  NUM_SLOTS*Y_W  flattened Y per slot, slot 0 in LSBs
rect_lane  out  NUM_SLOTS*clog2(NUM_LANES)  flattened lane per slot
rect_active  out  NUM_SLOTS  slot occupied
hit_pulse  out  NUM_LANES  registered, 1 frame: lane scored a hit
miss_pulse  out  NUM_LANES  registered, 1 frame: lane missed (despawn or empty hit)
hit_count  out  CNT_W  saturating total hits
miss_count  out  CNT_W  saturating total misses

Behaviour:
- Reset (async): all rect_active=0, rect_y=0, rect_lane=0, hit_pulse=0, miss_pulse=0, counters=0. Reset asserted mid-operation clears all slots immediately and never emits pulses.
- spawn_ready is combinational: OR of ~rect_active (registered flags). A slot freed this frame is not reusable until the next frame.
- Spawn: on edge with spawn_valid & spawn_ready, the lowest-index free slot gets y=spawn_y, lane=spawn_lane, active=1. The new rectangle does not move on its spawn edge; it moves from the following edge. spawn_lane >= NUM_LANES: request accepted, lane clamped to NUM_LANES-1.
- Motion (pause=0): every active slot not spawned/retired this edge: y <= y + speed. Sum computed in Y_W+1 bits; no wrap.
- Despawn: an active slot whose (y + speed) >= Y_LIMIT is cleared instead of moved. miss_pulse[lane]=1 and miss_count += 1 per despawned slot. Multiple despawns on the same lane in one frame: pulse once, count each.
- Hit: for each lane with hit_req=1 and pause=0, select the lowest-index active slot in that lane with HIT_LO <= y <= HIT_HI (current registered y). If found: clear it, hit_pulse[lane]=1, hit_count += 1. If not found: miss_pulse[lane]=1, miss_count += 1, no slot change.
- Priority on the same slot and edge: hit > despawn > move. At most one hit per lane per frame.
- Counters saturate at 2^CNT_W-1.
- pause=1: y, hits and despawns are frozen; hit_req ignored; pulses are 0; spawns proceed.
- Pulses are registered: they are high for exactly the frame following the triggering edge's evaluation, then return to 0.
- speed=0: rectangles are stationary; despawn occurs only if y >= Y_LIMIT already.

Test Plan:
- Reset, speed=2, spawn lane 1 y=0 -> slot 0 active, y=0 after spawn edge, 2 after next, 4 after next; spawn_ready stays 1.
- Fill all 8 slots on consecutive frames -> spawn_ready=0 after 8th; 9th request is held (not accepted) until a slot frees, then lands in the freed slot index.
- speed=4, spawn y=470 -> y=474, 478, then cleared on the following edge (482 >= 480); miss_pulse[lane] for 1 frame, miss_count=1.
- Slot at y=420 in lane 2, hit_req[2]=1 -> slot cleared, hit_pulse[2]=1, hit_count=1; hit_req[3] with lane 3 empty -> miss_pulse[3]=1, miss_count=1.
- Two lane-0 slots at y=410 (slot 1) and y=430 (slot 4), one hit -> only slot 1 cleared; pause=1 for 3 frames -> all y unchanged, hit_req ignored.
- Assert Reset while 5 slots are active and a hit is pending -> all outputs 0 immediately, no pulse, counters 0.
